// File: rtl/fnd_pkg.sv
// Shared types and constants for the four-digit FND scan front end.
package fnd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } conv_state_t;

  localparam int C_NUM_DIGITS = 4;
  localparam int C_BIN_WIDTH  = 14;
  localparam int C_BCD_WIDTH  = 4 * C_NUM_DIGITS;
  localparam logic [C_BIN_WIDTH-1:0] C_MAX_VALUE = 14'd9999;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Serial double-dabble converter: one shift/add-3 iteration per clock.
// done is high during the final iteration, so bcd is valid on the next cycle.
module bin_to_bcd_seq
  import fnd_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [C_BIN_WIDTH-1:0] value,
  output logic                   done,
  output logic [C_BCD_WIDTH-1:0] bcd
);

  logic                   running;
  logic [3:0]             count;
  logic [C_BIN_WIDTH-1:0] bin;
  logic [C_BCD_WIDTH-1:0] adjusted;

  always_comb begin
    adjusted = bcd;
    for (int d = 0; d < C_NUM_DIGITS; d++) begin
      if (bcd[d*4 +: 4] > 4'd4) begin
        adjusted[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  assign done = running && (count == 4'(C_BIN_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      bin     <= '0;
      bcd     <= '0;
    end else if (start && !running) begin
      running <= 1'b1;
      count   <= '0;
      bin     <= value;
      bcd     <= '0;
    end else if (running) begin
      {bcd, bin} <= {adjusted, bin} << 1;
      count      <= count + 4'd1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Binary-to-FND front end: converts a loaded value to BCD and scans the four
// digits onto the decode stage with optional leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int P_SCAN_DIV = 100_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_Load,
  input  logic [C_BIN_WIDTH-1:0] i_Binary,
  input  logic                   i_BlankLeadingZero,
  output logic                   o_Busy,
  output logic                   o_Overflow,
  output logic                   o_En,
  output logic [1:0]             o_DigitSelect,
  output logic [3:0]             o_Value
);

  localparam int PW = $clog2(P_SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(P_SCAN_DIV - 1);

  conv_state_t            state, next_state;
  logic                   start, commit, done;
  logic [C_BCD_WIDTH-1:0] bcd, display, upper;
  logic [C_BIN_WIDTH-1:0] clamped;
  logic [PW-1:0]          prescaler;
  logic [1:0]             scan_index;
  logic                   digit_en;

  assign clamped = (i_Binary > C_MAX_VALUE) ? C_MAX_VALUE : i_Binary;
  assign o_Busy  = (state != S_IDLE);

  bin_to_bcd_seq u_conv (
    .clk   (i_clk),
    .reset (i_reset),
    .start (start),
    .value (clamped),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Load) begin
          start      = 1'b1;
          next_state = S_CONV;
        end
      end
      S_CONV: begin
        if (done) begin
          next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit     = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The display only changes on commit, so a half-converted value is never scanned out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      display    <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (commit) begin
        display <= bcd;
      end
      if (start) begin
        o_Overflow <= (i_Binary > C_MAX_VALUE);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler  <= '0;
      scan_index <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler  <= '0;
      scan_index <= scan_index + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  assign upper    = display >> {scan_index, 2'b00};
  assign digit_en = (scan_index == 2'd0) || !i_BlankLeadingZero || (upper != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_En          <= 1'b0;
      o_DigitSelect <= '0;
      o_Value       <= '0;
    end else begin
      o_En          <= digit_en;
      o_DigitSelect <= scan_index;
      o_Value       <= display[{scan_index, 2'b00} +: 4];
    end
  end

endmodule
